// File: rtl/adc_pkg.sv
// Shared definitions for the ADC request arbiter: data width, FSM state
// encoding, the error code returned on a watchdog timeout, and
// width helpers used for parameter-derived counters.
package adc_pkg;

  localparam int ADC_DATA_W = 12;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_START_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
  localparam logic [2:0] ST_RESP_ENC  = 3'd3;
  localparam logic [2:0] ST_QUIET_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_RESP  = ST_RESP_ENC,
    ST_QUIET = ST_QUIET_ENC
  } arb_state_t;

  localparam logic [ADC_DATA_W-1:0] ADC_ERR_CODE = 12'hFFF;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width, kept within 8..16 bits.
  function automatic int wd_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8) begin
      w = 8;
    end else if (w > 16) begin
      w = 16;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_req_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals of the arbiter.
// slave  : the arbiter's view.
// master : the view of the surrounding logic (requesters + SPI master).
interface adc_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import adc_pkg::*;

  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [ADC_DATA_W-1:0] rsp_data;
  logic                  rsp_err;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  adc_start;
  logic [ADC_DATA_W-1:0] adc_data;
  logic                  adc_done;

  modport slave (
    input  req, adc_data, adc_done,
    output rsp_valid, rsp_data, rsp_err, grant_id, busy, adc_start
  );

  modport master (
    output req, adc_data, adc_done,
    input  rsp_valid, rsp_data, rsp_err, grant_id, busy, adc_start
  );

endinterface

// File: rtl/adc_req_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// found searching upward from last_grant+1, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  logic [IDW-1:0] cand_s;

  assign any = |req;

  // Walk candidates from the farthest to the nearest so that the nearest
  // requester after last_grant is the final (winning) assignment.
  always_comb begin
    idx    = '0;
    cand_s = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand_s]) begin
        idx = cand_s;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/adc_req_arbiter.sv
// Round-robin arbiter sharing one AD7476A SPI master between NUM_REQ
// requesters. One conversion per grant, sample routed back to the winner,
// and a quiet gap of QUIET_CYCLES clocks after each response.
// Optional build macro ADC_ARB_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYCLES clocks that answers with rsp_err=1 and ADC_ERR_CODE.
module adc_req_arbiter
  import adc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int QUIET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_req_arbiter_if.slave  bus
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int QW  = id_width(QUIET_CYCLES + 1);

  localparam logic [QW-1:0]      QUIET_LAST     = (QUIET_CYCLES > 0) ? QW'(QUIET_CYCLES - 1) : '0;
  localparam logic [NUM_REQ-1:0] ONE_HOT_BASE   = NUM_REQ'(1);
  localparam logic [IDW-1:0]     LAST_GRANT_RST = IDW'(NUM_REQ - 1);

  // Reject parameter sets outside the supported range at elaboration.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (QUIET_CYCLES < 0) ||
      (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_params
    $error("adc_req_arbiter: unsupported parameter values");
  end

  arb_state_t            state_r;
  logic [IDW-1:0]        last_grant_r;
  logic [IDW-1:0]        grant_id_r;
  logic                  busy_r;
  logic                  adc_start_r;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [ADC_DATA_W-1:0] rsp_data_r;
  logic [QW-1:0]         quiet_cnt_r;
  logic                  pick_any_s;
  logic [IDW-1:0]        pick_idx_s;

`ifdef ADC_ARB_TIMEOUT_EN
  localparam int TW = wd_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_cnt_r;
  logic          rsp_err_r;

  assign bus.rsp_err = rsp_err_r;
`else
  assign bus.rsp_err = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ    (NUM_REQ),
    .IDW        (IDW)
  ) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_grant_r),
    .any        (pick_any_s),
    .idx        (pick_idx_s)
  );

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.grant_id  = grant_id_r;
  assign bus.busy      = busy_r;
  assign bus.adc_start = adc_start_r;

  // Arbitration FSM: grant, start, wait for the sample, respond, quiet gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= LAST_GRANT_RST;
      grant_id_r   <= '0;
      busy_r       <= 1'b0;
      adc_start_r  <= 1'b0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
      quiet_cnt_r  <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
      wd_cnt_r     <= '0;
      rsp_err_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_id_r   <= pick_idx_s;
            last_grant_r <= pick_idx_s;
            busy_r       <= 1'b1;
            adc_start_r  <= 1'b1;
            state_r      <= ST_START;
          end else begin
            busy_r       <= 1'b0;
          end
        end
        ST_START: begin
          adc_start_r <= 1'b0;
          state_r     <= ST_WAIT;
`ifdef ADC_ARB_TIMEOUT_EN
          wd_cnt_r    <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.adc_done) begin
            rsp_data_r  <= bus.adc_data;
            rsp_valid_r <= ONE_HOT_BASE << grant_id_r;
            state_r     <= ST_RESP;
          end
`ifdef ADC_ARB_TIMEOUT_EN
          else if (wd_cnt_r == WD_LAST) begin
            rsp_data_r  <= ADC_ERR_CODE;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= ONE_HOT_BASE << grant_id_r;
            state_r     <= ST_RESP;
          end else begin
            wd_cnt_r    <= wd_cnt_r + TW'(1);
          end
`else
          else begin
            state_r     <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid_r <= '0;
          quiet_cnt_r <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
          rsp_err_r   <= 1'b0;
`endif
          if (QUIET_CYCLES > 0) begin
            state_r <= ST_QUIET;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_QUIET: begin
          if (quiet_cnt_r == QUIET_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            quiet_cnt_r <= quiet_cnt_r + QW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          adc_start_r <= 1'b0;
          rsp_valid_r <= '0;
        end
      endcase
    end
  end

endmodule
